// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings,
// stall-bit positions and common constant words.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

    // Bit positions inside the {ex_mem, id_ex, if_id, pc} stall vector.
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [3:0]  SelAll       = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction watchdog: counts busy cycles and flags the last allowed one.
module arb_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count busy cycles; hold once the limit is reached, restart on clear.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !expired_o) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired_o = (r_cnt == LastCount);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus port between instruction fetch and
// load/store, sequences each bus transaction, and drives pipeline stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_valid_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [3:0]  stall_o
);

    arb_state_e  r_state;
    arb_state_e  w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_if_last;
    logic [31:0] r_mem_last;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_owner_mem;
    logic        r_err;
    logic        r_discard;

    logic        w_busy;
    logic        w_expired;
    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_if_valid;
    logic        w_mem_valid;
    logic        w_mem_stall;
    logic        w_if_stall;
    logic [3:0]  w_stall;

    assign w_busy = (r_state == ST_IF_BUSY) || (r_state == ST_MEM_BUSY);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!w_busy),
        .en_i      (w_busy),
        .expired_o (w_expired)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and grant decode; MEM wins in IDLE since it is the older instruction.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    w_next      = ST_MEM_BUSY;
                    w_grant_mem = 1'b1;
                end else if (if_req_i) begin
                    w_next     = ST_IF_BUSY;
                    w_grant_if = 1'b1;
                end
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (bus_ack_i || w_expired) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the granted request and capture the response (or zero on timeout).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr      <= ZeroWord;
            r_wdata     <= ZeroWord;
            r_sel       <= 4'h0;
            r_we        <= WriteDisable;
            r_owner_mem <= 1'b0;
            r_rdata     <= ZeroWord;
            r_err       <= 1'b0;
        end else if (w_grant_mem) begin
            r_addr      <= mem_addr_i;
            r_wdata     <= mem_wdata_i;
            r_sel       <= mem_sel_i;
            r_we        <= mem_we_i;
            r_owner_mem <= 1'b1;
            r_err       <= 1'b0;
        end else if (w_grant_if) begin
            r_addr      <= if_addr_i;
            r_wdata     <= ZeroWord;
            r_sel       <= SelAll;
            r_we        <= WriteDisable;
            r_owner_mem <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_busy) begin
            if (bus_ack_i) begin
                r_rdata <= bus_rdata_i;
                r_err   <= 1'b0;
            end else if (w_expired) begin
                r_rdata <= ZeroWord;
                r_err   <= 1'b1;
            end
        end
    end

    // Discard flag: a branch flush during an IF access kills its result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_discard <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_discard <= 1'b0;
        end else if ((r_state == ST_IF_BUSY) && if_flush_i) begin
            r_discard <= 1'b1;
        end
    end

    // A flush arriving in RESP itself must also suppress the pulse.
    assign w_if_valid  = (r_state == ST_RESP) && !r_owner_mem && !r_discard && !if_flush_i;
    assign w_mem_valid = (r_state == ST_RESP) && r_owner_mem;

    // Hold the last delivered data so read data stays stable between pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_if_last  <= ZeroWord;
            r_mem_last <= ZeroWord;
        end else begin
            if (w_if_valid) begin
                r_if_last <= r_rdata;
            end
            if (w_mem_valid) begin
                r_mem_last <= r_rdata;
            end
        end
    end

    assign if_valid_o  = w_if_valid;
    assign mem_valid_o = w_mem_valid;
    assign if_rdata_o  = w_if_valid  ? r_rdata : r_if_last;
    assign mem_rdata_o = w_mem_valid ? r_rdata : r_mem_last;
    assign err_o       = r_err && (w_if_valid || w_mem_valid);

    assign bus_req_o   = w_busy;
    assign bus_we_o    = w_busy && r_we;
    assign bus_sel_o   = r_sel;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;

    // Stall vector: a pending load/store freezes everything, a pending fetch freezes pc and if_id.
    assign w_mem_stall = mem_req_i && !w_mem_valid;
    assign w_if_stall  = if_req_i && !w_if_valid;

    always_comb begin
        w_stall              = 4'b0000;
        w_stall[STALL_EXMEM] = w_mem_stall;
        w_stall[STALL_IDEX]  = w_mem_stall;
        w_stall[STALL_IFID]  = w_mem_stall || w_if_stall;
        w_stall[STALL_PC]    = w_mem_stall || w_if_stall;
    end

    assign stall_o = w_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_valid_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [3:0]  stall_o;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_sel_i   (mem_sel_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_valid_o (mem_valid_o),
        .err_o       (err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_sel_o   (bus_sel_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic to_pos;
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_neg;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i       = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        if_flush_i  = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'h0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        bus_rdata_i = 32'h0;
        bus_ack_i   = 1'b0;

        // Reset state
        #2;
        check("rst_bus_req",   bus_req_o,   0);
        check("rst_stall",     stall_o,     0);
        check("rst_if_valid",  if_valid_o,  0);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_err",       err_o,       0);
        check("rst_if_rdata",  if_rdata_o,  0);
        check("rst_bus_addr",  bus_addr_o,  0);
        to_neg;
        rst_i = 1'b1;

        // IF read only
        to_pos;
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        to_neg;
        check("s1_idle_stall", stall_o,   4'b0011);
        check("s1_idle_req",   bus_req_o, 0);
        to_pos;
        to_neg;
        check("s1_busy_req",  bus_req_o,  1);
        check("s1_busy_addr", bus_addr_o, 32'h100);
        check("s1_busy_we",   bus_we_o,   0);
        check("s1_busy_sel",  bus_sel_o,  4'hF);
        to_pos;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0050_0093;
        to_neg;
        check("s1_ack_valid", if_valid_o, 0);
        check("s1_ack_stall", stall_o,    4'b0011);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s1_resp_valid", if_valid_o, 1);
        check("s1_resp_rdata", if_rdata_o, 32'h0050_0093);
        check("s1_resp_stall", stall_o,    4'b0000);
        check("s1_resp_err",   err_o,      0);
        check("s1_resp_req",   bus_req_o,  0);
        to_pos;
        if_req_i = 1'b0;
        to_neg;
        check("s1_idle_valid", if_valid_o, 0);
        check("s1_hold_rdata", if_rdata_o, 32'h0050_0093);

        // Simultaneous requests: MEM store first, then IF
        if_req_i    = 1'b1;
        if_addr_i   = 32'h200;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h2000;
        mem_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("s2_idle_stall", stall_o, 4'b1111);
        to_pos;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1111_1111;
        to_neg;
        check("s2_busy_req",   bus_req_o,   1);
        check("s2_busy_we",    bus_we_o,    1);
        check("s2_busy_addr",  bus_addr_o,  32'h2000);
        check("s2_busy_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        check("s2_busy_sel",   bus_sel_o,   4'hF);
        check("s2_busy_stall", stall_o,     4'b1111);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s2_mem_valid",  mem_valid_o, 1);
        check("s2_mem_rdata",  mem_rdata_o, 32'h1111_1111);
        check("s2_if_valid",   if_valid_o,  0);
        check("s2_resp_stall", stall_o,     4'b0011);
        check("s2_resp_req",   bus_req_o,   0);
        to_pos;
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        to_neg;
        check("s2_idle_req",   bus_req_o,   0);
        check("s2_idle_valid", mem_valid_o, 0);
        to_pos;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        to_neg;
        check("s2_if_req",   bus_req_o,   1);
        check("s2_if_addr",  bus_addr_o,  32'h200);
        check("s2_if_we",    bus_we_o,    0);
        check("s2_if_wdata", bus_wdata_o, 32'h0);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s2_if_valid2", if_valid_o, 1);
        check("s2_if_rdata",  if_rdata_o, 32'h1234_5678);
        to_pos;
        if_req_i = 1'b0;

        // Timeout on a MEM load with no ack
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'h3;
        mem_addr_i = 32'h3000;
        to_pos;
        to_neg;
        check("s3_sel",  bus_sel_o,  4'h3);
        check("s3_addr", bus_addr_o, 32'h3000);
        to_pos;
        for (int i = 1; i < TIMEOUT; i++) begin
            to_neg;
            check($sformatf("s3_busy_%0d", i), bus_req_o, 1);
            to_pos;
        end
        to_neg;
        check("s3_to_req",   bus_req_o,   0);
        check("s3_to_valid", mem_valid_o, 1);
        check("s3_to_err",   err_o,       1);
        check("s3_to_rdata", mem_rdata_o, 32'h0);
        to_pos;
        mem_req_i = 1'b0;
        to_neg;
        check("s3_after_err",   err_o,       0);
        check("s3_after_valid", mem_valid_o, 0);
        check("s3_after_rdata", mem_rdata_o, 32'h0);

        // Flush during an IF access
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        to_pos;
        if_flush_i = 1'b1;
        if_addr_i  = 32'h180;
        to_neg;
        check("s4_busy_addr", bus_addr_o, 32'h104);
        to_pos;
        if_flush_i  = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hAAAA_5555;
        to_neg;
        check("s4_ack_req",  bus_req_o,  1);
        check("s4_ack_addr", bus_addr_o, 32'h104);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s4_resp_valid", if_valid_o, 0);
        check("s4_resp_rdata", if_rdata_o, 32'h1234_5678);
        check("s4_resp_stall", stall_o,    4'b0011);
        to_pos;
        to_neg;
        check("s4_idle_req", bus_req_o, 0);
        to_pos;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0000_BEEF;
        to_neg;
        check("s4_new_addr", bus_addr_o, 32'h180);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s4_new_valid", if_valid_o, 1);
        check("s4_new_rdata", if_rdata_o, 32'h0000_BEEF);
        to_pos;
        if_req_i = 1'b0;

        // Reset asserted mid MEM access
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h4000;
        to_pos;
        to_neg;
        check("s5_busy_req", bus_req_o, 1);
        #1;
        rst_i = 1'b0;
        #1;
        check("s5_async_req",    bus_req_o,  0);
        check("s5_async_rdata",  if_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        to_pos;
        to_neg;
        check("s5_rst_valid", mem_valid_o, 0);
        check("s5_rst_req",   bus_req_o,   0);
        rst_i = 1'b1;
        to_pos;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h5000;
        to_neg;
        check("s5_idle_req", bus_req_o, 0);
        to_pos;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        to_neg;
        check("s5_new_req",  bus_req_o,  1);
        check("s5_new_addr", bus_addr_o, 32'h5000);
        to_pos;
        bus_ack_i = 1'b0;
        to_neg;
        check("s5_new_valid", mem_valid_o, 1);
        check("s5_new_rdata", mem_rdata_o, 32'hCAFE_F00D);
        to_pos;
        mem_req_i = 1'b0;

        // Spurious ack while IDLE
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h7777_7777;
        to_neg;
        check("s6_req0",       bus_req_o,   0);
        check("s6_mem_valid0", mem_valid_o, 0);
        check("s6_if_valid0",  if_valid_o,  0);
        to_pos;
        to_neg;
        check("s6_req1",       bus_req_o,   0);
        check("s6_mem_valid1", mem_valid_o, 0);
        check("s6_mem_rdata",  mem_rdata_o, 32'hCAFE_F00D);
        bus_ack_i = 1'b0;
        to_pos;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
